// File: rtl/core_pkg.sv
// Shared core types and constants for the integer register file writeback path.
package core_pkg;

  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 5;
  localparam int NREQ      = 3;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
    logic [63:0]          pc;
    logic [31:0]          inst;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Single-grant writeback arbiter. WB_ARB_RR_EN selects round-robin with a pointer;
// otherwise fixed priority LSU(1) > MDU(2) > ALU(0) with no state.
module wb_rr_arbiter #(
  parameter int NREQ = 3
) (
`ifdef WB_ARB_RR_EN
  input  logic            clk,
  input  logic            rst,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

`ifdef WB_ARB_RR_EN
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_nxt_s;
  logic             found_s;
  int               idx_s;

  // Search starting at the pointer; next pointer is one past the winner.
  always_comb begin
    gnt       = {NREQ{1'b0}};
    ptr_nxt_s = ptr_r;
    found_s   = 1'b0;
    idx_s     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr_r) + k) % NREQ;
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
        ptr_nxt_s  = (idx_s == NREQ - 1) ? {PTR_W{1'b0}} : PTR_W'(idx_s + 1);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register; req is already masked upstream so any hit is a real grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (found_s) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  logic found_s;
  int   idx_s;

  // Fixed order 1, 2, ..., NREQ-1, then 0.
  always_comb begin
    gnt     = {NREQ{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (k == NREQ - 1) ? 0 : k + 1;
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register file write-port controller: arbitrated registered commit stage plus
// RAW/WAW scoreboard. Optional WB_ARB_RR_EN selects round-robin arbitration.
module regfile_wb_ctrl #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*5-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic [NREQ*64-1:0]  req_pc,
  input  logic [NREQ*32-1:0]  req_inst,
  input  logic                iss_valid,
  input  logic [4:0]          iss_rd,
  input  logic [4:0]          iss_rs1,
  input  logic [4:0]          iss_rs2,
  output logic                iss_ready,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                we,
  output logic [4:0]          waddr,
  output logic [XLEN-1:0]     wdata,
  output logic [63:0]         debug_wb_pc,
  output logic [31:0]         debug_wb_inst
);

  localparam int IDX_W = core_pkg::REG_IDX_W;
  localparam int NREG  = 1 << IDX_W;

  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic              set_s;
  logic [NREQ-1:0]   arb_req_s;
  logic [NREQ-1:0]   gnt_s;
  logic              any_gnt_s;
  core_pkg::wb_req_t sel_s;

  logic              we_r;
  logic [IDX_W-1:0]  waddr_r;
  logic [XLEN-1:0]   wdata_r;
  logic [63:0]       pc_r;
  logic [31:0]       inst_r;

  // Reset and flush suppress any grant, which also keeps the RR pointer still.
  assign arb_req_s = req_valid & {NREQ{!(rst || flush)}};

  wb_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
`ifdef WB_ARB_RR_EN
    .clk  (clk),
    .rst  (rst),
`endif
    .req  (arb_req_s),
    .gnt  (gnt_s)
  );

  assign req_ready = gnt_s;
  assign any_gnt_s = |gnt_s;

  // Mux the granted requester's payload.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        sel_s.rd   = req_rd[i*IDX_W +: IDX_W];
        sel_s.data = req_data[i*XLEN +: XLEN];
        sel_s.pc   = req_pc[i*64 +: 64];
        sel_s.inst = req_inst[i*32 +: 32];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // WAW stall guarantees one in-flight write per register; index 0 never stalls.
  assign iss_ready = !(busy_r[iss_rd] && (iss_rd != 5'd0));
  assign set_s     = iss_valid && iss_ready && (iss_rd != 5'd0);

  // A write committing this cycle is forwarded by the register file, so it is not busy.
  assign rs1_busy = busy_r[iss_rs1] && !(we_r && (waddr_r == iss_rs1));
  assign rs2_busy = busy_r[iss_rs2] && !(we_r && (waddr_r == iss_rs2));

  // Scoreboard next state: clear on commit, set on dispatch.
  always_comb begin
    busy_nxt_s = busy_r;
    if (we_r) begin
      busy_nxt_s[waddr_r] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (set_s) begin
      busy_nxt_s[iss_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
    end else if (flush) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Commit stage; debug PC/instruction hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      waddr_r <= {IDX_W{1'b0}};
      wdata_r <= {XLEN{1'b0}};
      pc_r    <= 64'd0;
      inst_r  <= 32'd0;
    end else if (flush) begin
      we_r <= 1'b0;
    end else if (any_gnt_s) begin
      we_r    <= (sel_s.rd != 5'd0);
      waddr_r <= sel_s.rd;
      wdata_r <= sel_s.data;
      pc_r    <= sel_s.pc;
      inst_r  <= sel_s.inst;
    end else begin
      we_r <= 1'b0;
    end
  end

  assign we            = we_r;
  assign waddr         = waddr_r;
  assign wdata         = wdata_r;
  assign debug_wb_pc   = pc_r;
  assign debug_wb_inst = inst_r;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: commits scored through an expected-result queue.
module tb_regfile_wb_ctrl;

  localparam int NREQ = 3;
  localparam int XLEN = 64;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ*64-1:0]   req_pc;
  logic [NREQ*32-1:0]   req_inst;
  logic                 iss_valid;
  logic [4:0]           iss_rd;
  logic [4:0]           iss_rs1;
  logic [4:0]           iss_rs2;
  logic                 iss_ready;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 we;
  logic [4:0]           waddr;
  logic [XLEN-1:0]      wdata;
  logic [63:0]          debug_wb_pc;
  logic [31:0]          debug_wb_inst;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        q[$];
  int          errors;
  int          checks;
  logic [63:0] last_pc;
  logic [31:0] last_inst;
  int          seq[NREQ];
  int          n_cont;
  logic [2:0]  vld_tab[5];
  logic [2:0]  gnt_tab[5];

  regfile_wb_ctrl #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rd        (req_rd),
    .req_data      (req_data),
    .req_pc        (req_pc),
    .req_inst      (req_inst),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .iss_rs1       (iss_rs1),
    .iss_rs2       (iss_rs2),
    .iss_ready     (iss_ready),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .debug_wb_pc   (debug_wb_pc),
    .debug_wb_inst (debug_wb_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [63:0] d,
                         input logic [63:0] pc, input logic [31:0] inst);
    req_rd[i*5 +: 5]       = rd;
    req_data[i*64 +: 64]   = d;
    req_pc[i*64 +: 64]     = pc;
    req_inst[i*32 +: 32]   = inst;
  endtask

  task automatic push_exp(input logic w, input logic [4:0] a, input logic [63:0] d,
                          input logic [63:0] pc, input logic [31:0] inst);
    exp_t e;
    e.we = w; e.waddr = a; e.wdata = d; e.pc = pc; e.inst = inst;
    q.push_back(e);
  endtask

  // Registered outputs are stable at the falling edge; score them against the queue.
  task automatic check_commit();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("commit_we", {63'd0, we}, {63'd0, e.we});
      chk("commit_waddr", {59'd0, waddr}, {59'd0, e.waddr});
      chk("commit_wdata", wdata, e.wdata);
      chk("commit_pc", debug_wb_pc, e.pc);
      chk("commit_inst", {32'd0, debug_wb_inst}, {32'd0, e.inst});
      last_pc   = e.pc;
      last_inst = e.inst;
    end else begin
      chk("idle_we", {63'd0, we}, 64'd0);
      chk("idle_pc_hold", debug_wb_pc, last_pc);
      chk("idle_inst_hold", {32'd0, debug_wb_inst}, {32'd0, last_inst});
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    check_commit();
  endtask

  task automatic load_cont(input int i);
    set_req(i, 5'(10 + i), {32'hC0DE0000 + 32'(i), 32'(seq[i])},
            64'h3000 + 64'(i * 16) + 64'(seq[i] * 4), 32'h1000 + 32'(i));
  endtask

  initial begin
    errors = 0; checks = 0;
    last_pc = 64'd0; last_inst = 32'd0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
`ifdef WB_ARB_RR_EN
    n_cont = 3;
    vld_tab[0] = 3'b111; gnt_tab[0] = 3'b001;
    vld_tab[1] = 3'b110; gnt_tab[1] = 3'b010;
    vld_tab[2] = 3'b100; gnt_tab[2] = 3'b100;
    vld_tab[3] = 3'b000; gnt_tab[3] = 3'b000;
    vld_tab[4] = 3'b000; gnt_tab[4] = 3'b000;
`else
    n_cont = 5;
    vld_tab[0] = 3'b111; gnt_tab[0] = 3'b010;
    vld_tab[1] = 3'b111; gnt_tab[1] = 3'b010;
    vld_tab[2] = 3'b111; gnt_tab[2] = 3'b010;
    vld_tab[3] = 3'b101; gnt_tab[3] = 3'b100;
    vld_tab[4] = 3'b001; gnt_tab[4] = 3'b001;
`endif

    rst = 1'b1; flush = 1'b0;
    iss_valid = 1'b0; iss_rd = 5'd5; iss_rs1 = 5'd5; iss_rs2 = 5'd7;
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 64'h1111 * 64'(i + 1), 64'h4000, 32'h13);

    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_req_ready", {61'd0, req_ready}, 64'd0);
      chk("rst_we", {63'd0, we}, 64'd0);
      chk("rst_waddr", {59'd0, waddr}, 64'd0);
      chk("rst_wdata", wdata, 64'd0);
      chk("rst_pc", debug_wb_pc, 64'd0);
      chk("rst_inst", {32'd0, debug_wb_inst}, 64'd0);
      chk("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
      chk("rst_iss_ready", {63'd0, iss_ready}, 64'd1);
    end

    next_cycle();
    rst = 1'b0; req_valid = 3'b000;

    // Single write to x5
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1 chk("sw_iss_ready", {63'd0, iss_ready}, 64'd1);
    next_cycle();
    iss_valid = 1'b0; iss_rs1 = 5'd5;
    set_req(0, 5'd5, 64'hDEAD_BEEF, 64'h1000, 32'h0050_0293);
    req_valid = 3'b001;
    #1;
    chk("sw_rs1_busy_set", {63'd0, rs1_busy}, 64'd1);
    chk("sw_req_ready", {61'd0, req_ready}, 64'b001);
    push_exp(1'b1, 5'd5, 64'hDEAD_BEEF, 64'h1000, 32'h0050_0293);
    next_cycle();
    req_valid = 3'b000;
    #1;
    chk("sw_rs1_bypass", {63'd0, rs1_busy}, 64'd0);
    chk("sw_iss_ready_commit", {63'd0, iss_ready}, 64'd0);
    next_cycle();
    #1;
    chk("sw_rs1_cleared", {63'd0, rs1_busy}, 64'd0);
    chk("sw_iss_ready_cleared", {63'd0, iss_ready}, 64'd1);

    // WAW on x7
    next_cycle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1 chk("waw_first_ready", {63'd0, iss_ready}, 64'd1);
    next_cycle();
    set_req(2, 5'd7, 64'h77, 64'h1004, 32'h0270_03b3);
    req_valid = 3'b100;
    #1;
    chk("waw_stall", {63'd0, iss_ready}, 64'd0);
    chk("waw_req_ready", {61'd0, req_ready}, 64'b100);
    push_exp(1'b1, 5'd7, 64'h77, 64'h1004, 32'h0270_03b3);
    next_cycle();
    req_valid = 3'b000;
    #1 chk("waw_stall_commit", {63'd0, iss_ready}, 64'd0);
    next_cycle();
    #1 chk("waw_release", {63'd0, iss_ready}, 64'd1);
    next_cycle();
    iss_valid = 1'b0;

    // Contention
    for (int c = 0; c < n_cont; c++) begin
      req_valid = vld_tab[c];
      for (int i = 0; i < NREQ; i++) load_cont(i);
      #1;
      chk($sformatf("cont_gnt_%0d", c), {61'd0, req_ready}, {61'd0, gnt_tab[c]});
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_tab[c][i]) begin
          push_exp(1'b1, 5'(10 + i), {32'hC0DE0000 + 32'(i), 32'(seq[i])},
                   64'h3000 + 64'(i * 16) + 64'(seq[i] * 4), 32'h1000 + 32'(i));
          seq[i]++;
        end
      end
      next_cycle();
    end

    // rd=0 request from LSU
    req_valid = 3'b010;
    set_req(1, 5'd0, 64'h5555, 64'h8000_0010, 32'h0000_0073);
    #1 chk("rd0_req_ready", {61'd0, req_ready}, 64'b010);
    push_exp(1'b0, 5'd0, 64'h5555, 64'h8000_0010, 32'h0000_0073);
    next_cycle();
    req_valid = 3'b000;
    next_cycle();

    // Flush with three busy registers and an in-flight grant
    iss_valid = 1'b1; iss_rd = 5'd3;
    next_cycle();
    iss_rd = 5'd4;
    next_cycle();
    iss_rd = 5'd6;
    next_cycle();
    iss_valid = 1'b0; iss_rs1 = 5'd3; iss_rs2 = 5'd4;
    set_req(2, 5'd6, 64'h66, 64'h2000, 32'h0060_0313);
    req_valid = 3'b100;
    #1;
    chk("fl_rs1_busy", {63'd0, rs1_busy}, 64'd1);
    chk("fl_rs2_busy", {63'd0, rs2_busy}, 64'd1);
    chk("fl_iss_ready_x6", {63'd0, iss_ready}, 64'd0);
    chk("fl_pre_req_ready", {61'd0, req_ready}, 64'b100);
    push_exp(1'b1, 5'd6, 64'h66, 64'h2000, 32'h0060_0313);
    next_cycle();
    flush = 1'b1;
    set_req(0, 5'd9, 64'h99, 64'h2004, 32'h0090_0493);
    req_valid = 3'b001;
    #1 chk("fl_req_ready", {61'd0, req_ready}, 64'd0);
    next_cycle();
    flush = 1'b0; req_valid = 3'b000; iss_rd = 5'd7;
    #1;
    chk("fl_rs1_clear", {63'd0, rs1_busy}, 64'd0);
    chk("fl_rs2_clear", {63'd0, rs2_busy}, 64'd0);
    chk("fl_iss_ready_x7", {63'd0, iss_ready}, 64'd1);
    next_cycle();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller and scoreboard for the 64-bit, 32-entry integer register file. It arbitrates N writeback requesters (ALU, LSU, MDU) onto the register file's single write port through a registered commit stage. It also tracks destination registers with pending writes, so issue can stall on RAW/WAW hazards. It sits between the execute units and the register file, and drives the write port plus the debug writeback PC/instruction used by difftest.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters; index 0 = ALU, 1 = LSU, 2 = MDU.
- XLEN, 64, data width.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; clears scoreboard and commit stage.
- req_valid  in  NREQ  requester i holds a result.
- req_ready  out  NREQ  requester i accepted this cycle.
- req_rd  in  NREQ*5  destination index per requester.
- req_data  in  NREQ*XLEN  result per requester.
- req_pc  in  NREQ*64  instruction PC per requester.
- req_inst  in  NREQ*32  instruction word per requester.
- iss_valid  in  1  issue stage wants to dispatch.
- iss_rd  in  5  destination of the dispatching instruction.
- iss_rs1  in  5  first source index.
- iss_rs2  in  5  second source index.
- iss_ready  out  1  dispatch allowed.
- rs1_busy  out  1  iss_rs1 has a pending, not-yet-bypassable write.
- rs2_busy  out  1  same for iss_rs2.
- we  out  1  register file write enable.
- waddr  out  5  register file write index.
- wdata  out  XLEN  register file write data.
- debug_wb_pc  out  64  PC of the committed instruction.
- debug_wb_inst  out  32  instruction word of the committed instruction.

## Operation
- The scoreboard `busy[31:0]` has bit 0 hardwired to 0.
- Dispatch: `iss_ready = !(busy[iss_rd] && iss_rd!=0)`. This is a WAW stall, so at most one in-flight write exists per register.
  - On `iss_valid && iss_ready && iss_rd!=0`, set `busy[iss_rd]`.
- Arbitration: at most one grant per cycle among the asserted `req_valid` bits.
  - `req_ready[i]` is 1 only for the granted requester.
  - Requesters must hold valid and payload stable until ready.
- Commit stage: the granted payload is registered.
  - Next cycle `we = (rd!=0)`, `waddr = rd`, `wdata = data`, and `debug_wb_pc`/`debug_wb_inst` are loaded.
  - With no grant, `we = 0` and the debug outputs hold their last value.
- Clear: in a cycle with `we = 1`, `busy[waddr]` is cleared at the closing edge. This is the same edge at which the register file writes.
- rd=0 request: accepted normally. It produces `we = 0` but still updates the debug PC/instruction.
- Busy outputs: `rsN_busy = busy[iss_rsN] && !(we && waddr==iss_rsN)`, relying on the register file's write-through bypass. Both are 0 when the index is 0.
- Simultaneous set and clear of different indices both take effect.
- The same index cannot be set and cleared in the same cycle, because `iss_ready` is low for it.
- flush: clears all busy bits, forces `we = 0` next cycle, and drops any grant that cycle (`req_ready` = 0).
  - Outstanding requesters are flushed by their owners.
- Reset:
  - `busy = 0`, `we = 0`, `waddr = 0`, `wdata = 0`.
  - `debug_wb_pc = 0`, `debug_wb_inst = 0`.
  - Round-robin pointer = 0; `req_ready = 0` while rst is high.

## Timing
- Request-to-write latency: 1 cycle. Grant at cycle N, write performed at the end of N+1.
- Throughput: one commit per cycle.
- `iss_ready`, `rsN_busy` and `req_ready` are combinational from inputs and state. There is no combinational path from `req_*` to `iss_ready`.
- A scoreboard set at dispatch edge E makes `busy` visible from cycle E+1.
- Reset mid-operation discards the commit stage and loses pending writes; the core restarts from the reset PC.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer advances to (granted index + 1) mod NREQ after each grant.
  - Search starts at the pointer.
- Not defined: fixed priority, LSU(1) > MDU(2) > ALU(0), and no pointer state.
- Grant/commit timing is identical in both modes.

## Structure
- Shared package `core_pkg` holds:
  - `XLEN`, `REG_IDX_W = 5`, `NREQ`;
  - requester index constants `WB_ALU`, `WB_LSU`, `WB_MDU`;
  - a `wb_req_t` struct (rd, data, pc, inst).
- One sub-module, `wb_rr_arbiter`: `req[NREQ]` in, one-hot `gnt` out, internal pointer under `WB_ARB_RR_EN`.
- Scoreboard and commit register stay in `regfile_wb_ctrl`.

## Test plan
- Reset: assert rst 2 cycles with all valids high.
  - Expect `req_ready = 0`, `we = 0`, `busy = 0`, `debug_wb_pc = 0`.
- Single write: dispatch rd=5, then ALU req rd=5, data=0xDEAD_BEEF.
  - Expect `req_ready[0]` at cycle N; `we = 1`, `waddr = 5`, `wdata = 0xDEADBEEF` at N+1.
  - Expect `rs1_busy(5) = 0` at N+1 and `busy[5] = 0` at N+2.
- WAW stall: dispatch rd=7, then dispatch rd=7 again.
  - Expect `iss_ready = 0` until the cycle after the rd=7 commit.
- Contention: all 3 requesters valid for 3 cycles.
  - RR mode: grants 0, 1, 2.
  - Fixed mode: grant 1 repeatedly while it stays valid.
- rd=0: LSU req rd=0, pc=0x8000_0010.
  - Expect `we = 0`, `debug_wb_pc = 0x80000010`.
- Flush: 3 busy registers plus a pending grant cycle, then flush.
  - Expect `busy = 0`, `req_ready = 0` in the flush cycle, `we = 0` the next cycle.
